// File: rtl/diff_capture.sv
// Trigger-armed snapshot buffer: after arm, the first en-qualified co stores DEPTH
// samples, replays them over a valid/ready port, then waits HOLDOFF en cycles.
//
// state     | meaning
// S_IDLE    | waiting for arm; co ignored
// S_ARMED   | waiting for en&co trigger
// S_CAPTURE | filling buffer on en cycles
// S_DRAIN   | replaying buffer over out_valid/out_ready
// S_HOLDOFF | counting down HOLDOFF en cycles
module diff_capture #(
    parameter int DW      = 24,
    parameter int DEPTH   = 16,
    parameter int HOLDOFF = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 co,
    input  logic signed [DW-1:0] data,
    input  logic                 arm,
    output logic signed [DW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          event_cnt,
    output logic [7:0]           missed_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLDOFF + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DRAIN,
        S_HOLDOFF
    } state_t;

    state_t state, state_nxt;

    logic signed [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, wr_addr;
    logic [HW-1:0] hcnt;
    logic          wr_en, trig, miss, rd_adv, hold_load, hold_tick, done_nxt;

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = wptr;
        trig      = 1'b0;
        miss      = 1'b0;
        rd_adv    = 1'b0;
        hold_load = 1'b0;
        hold_tick = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (en && co) begin
                    trig      = 1'b1;
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                miss = en && co;
                if (en) begin
                    wr_en = 1'b1;
                    if (wptr == AW'(DEPTH - 1)) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                miss = en && co;
                if (out_ready) begin
                    rd_adv = 1'b1;
                    if (rptr == AW'(DEPTH - 1)) begin
                        hold_load = 1'b1;
                        state_nxt = S_HOLDOFF;
                    end
                end
            end
            S_HOLDOFF: begin
                miss = en && co;
                if (en) begin
                    hold_tick = 1'b1;
                    if (hcnt == HW'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            rptr       <= '0;
            hcnt       <= '0;
            done       <= 1'b0;
            event_cnt  <= '0;
            missed_cnt <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            // the trigger sample lands in slot 0, so the capture pointer restarts at 1
            if (trig)       wptr <= AW'(1);
            else if (wr_en) wptr <= wptr + AW'(1);
            if (trig)        rptr <= '0;
            else if (rd_adv) rptr <= rptr + AW'(1);
            if (hold_load)      hcnt <= HW'(HOLDOFF);
            else if (hold_tick) hcnt <= hcnt - HW'(1);
            if (trig && event_cnt != 16'hFFFF) event_cnt <= event_cnt + 16'd1;
            if (miss && missed_cnt != 8'hFF)   missed_cnt <= missed_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data;
    end

    assign out_valid = (state == S_DRAIN);
    assign busy      = (state != S_IDLE);
    assign out_data  = mem[rptr];

endmodule

// File: tb/tb_diff_capture.sv
// Directed bench for diff_capture (DEPTH=4, HOLDOFF=2) with a queue-based scoreboard
// checking every drained sample independently of the stimulus thread.
module tb_diff_capture;

    localparam int DW      = 24;
    localparam int DEPTH   = 4;
    localparam int HOLDOFF = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0, co = 1'b0, arm = 1'b0, out_ready = 1'b0;
    logic signed [DW-1:0] data = '0;
    logic signed [DW-1:0] out_data;
    logic                 out_valid, busy, done;
    logic [15:0]          event_cnt;
    logic [7:0]           missed_cnt;

    int total = 0;
    int bad   = 0;
    logic signed [DW-1:0] exp_q[$];

    diff_capture #(.DW(DW), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst(rst), .en(en), .co(co), .data(data), .arm(arm),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .event_cnt(event_cnt), .missed_cnt(missed_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic c, input logic a,
                       input int d, input logic r);
        en = e; co = c; arm = a; data = DW'(d); out_ready = r;
        @(posedge clk);
        #1;
        arm = 1'b0; co = 1'b0;
    endtask

    // capture DEPTH samples starting at base with en=1, expected pushed as issued
    task automatic capture(input int base, input logic co_mid);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, base, 0);
        exp_q.push_back(DW'(base));
        for (int i = 1; i < DEPTH; i++) begin
            cyc(1, (i == 1) ? co_mid : 1'b0, 0, base + i, 0);
            exp_q.push_back(DW'(base + i));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got data=%0d expected no output", out_data);
            end else if (out_ready) begin
                chk("drain_data", out_data, exp_q.pop_front());
            end else begin
                chk("stall_hold", out_data, exp_q[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_missed;
        exp_missed = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_event", event_cnt, 0);
        chk("rst_missed", missed_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic capture, drain, holdoff, done
        cyc(1, 1, 0, 5, 1);
        chk("idle_co_ignored", busy, 0);
        capture(10, 1'b0);
        chk("drain_first_valid", out_valid, 1);
        chk("drain_first_data", out_data, 10);
        chk("event_after_1", event_cnt, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, 1);
        chk("post_drain_valid", out_valid, 0);
        chk("holdoff_busy", busy, 1);
        cyc(1, 0, 0, 0, 0);
        chk("holdoff1_done", done, 0);
        chk("holdoff1_busy", busy, 1);
        cyc(1, 0, 0, 0, 0);
        chk("done_pulse", done, 1);
        chk("idle_busy", busy, 0);
        cyc(1, 0, 0, 0, 0);
        chk("done_single", done, 0);
        chk("q_empty_1", exp_q.size(), 0);

        // drain with stalls
        capture(20, 1'b0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("stall_valid", out_valid, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("stall_remaining", exp_q.size(), 1);
        cyc(1, 0, 0, 0, 1);
        chk("q_empty_2", exp_q.size(), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("done_2", done, 1);
        chk("event_after_2", event_cnt, 2);

        // triggers while busy are counted as missed only
        capture(30, 1'b1);
        exp_missed++;
        cyc(1, 1, 0, 0, 1);
        exp_missed++;
        for (int i = 1; i < DEPTH; i++) cyc(1, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 0);
        exp_missed++;
        chk("holdoff_co_busy", busy, 1);
        cyc(1, 0, 0, 0, 0);
        chk("done_3", done, 1);
        chk("missed_3", missed_cnt, exp_missed);
        chk("event_after_3", event_cnt, 3);
        chk("q_empty_3", exp_q.size(), 0);

        // arm and co together: arm only
        cyc(1, 1, 1, 40, 0);
        chk("armco_event", event_cnt, 3);
        chk("armco_busy", busy, 1);
        cyc(1, 0, 0, 99, 0);
        chk("armed_wait_valid", out_valid, 0);
        cyc(1, 1, 0, 41, 0);
        exp_q.push_back(DW'(41));
        chk("late_trigger_event", event_cnt, 4);
        for (int i = 1; i < DEPTH; i++) begin
            cyc(1, 0, 0, 41 + i, 0);
            exp_q.push_back(DW'(41 + i));
        end
        for (int i = 0; i < DEPTH + HOLDOFF; i++) cyc(1, 0, 0, 0, 1);
        chk("done_4", done, 1);
        chk("q_empty_4", exp_q.size(), 0);

        // gaps in en during capture; drain runs with en=0
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, -50, 0);
        exp_q.push_back(DW'(-50));
        for (int i = 1; i < DEPTH; i++) begin
            cyc(0, 0, 0, 90 + i, 0);
            cyc(1, 0, 0, -50 - i, 0);
            exp_q.push_back(DW'(-50 - i));
        end
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1);
        chk("q_empty_5", exp_q.size(), 0);
        cyc(0, 0, 0, 0, 0);
        chk("holdoff_needs_en", busy, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("done_5", done, 1);

        // reset during drain
        capture(60, 1'b0);
        cyc(1, 0, 0, 0, 1);
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_event", event_cnt, 0);
        chk("rst_mid_missed", missed_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 70 + i, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_event", event_cnt, 0);
        capture(80, 1'b0);
        chk("rearm_event", event_cnt, 1);
        for (int i = 0; i < DEPTH + HOLDOFF; i++) cyc(1, 0, 0, 0, 1);
        chk("done_6", done, 1);
        chk("q_empty_6", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
